// File: rtl/pipeline_pkg.sv
// Shared constants for the MIPS pipeline stages.
//   - aluop classes produced by decode
//   - ALU control codes consumed by the ALU datapath
//   - R-type funct field values
//   - bit positions inside the WB and M control bundles
package pipeline_pkg;

  // aluop classes from decode
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  // ALU control codes
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_NOP = 3'b011;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // R-type funct values (instruction bits [5:0])
  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  // Bit positions within wb_ctl = {regwrite, memtoreg}
  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;

  // Bit positions within m_ctl = {branch, memread, memwrite}
  localparam int M_BRANCH   = 2;
  localparam int M_MEMREAD  = 1;
  localparam int M_MEMWRITE = 0;

endpackage

// File: rtl/alu.sv
// Combinational ALU for the execute stage: ALU-control decode plus datapath.
// Ports:
//   aluop  [1:0]        op class from decode
//   funct  [5:0]        funct field, only meaningful when aluop is R-type
//   a, b   [DATA_W-1:0] operands
//   result [DATA_W-1:0] ALU result (0 for NOP / unknown ops)
//   zero                result == 0
module alu
  import pipeline_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [1:0]        aluop,
  input  logic [5:0]        funct,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              zero
);

  logic [2:0] alu_ctl;

  // aluop=11 and unrecognised functs both fall to NOP so the result is a
  // well-defined 0 rather than whatever the adder happens to produce.
  always_comb begin
    alu_ctl = ALU_NOP;
    case (aluop)
      ALUOP_ADD: alu_ctl = ALU_ADD;
      ALUOP_SUB: alu_ctl = ALU_SUB;
      ALUOP_RTYPE: begin
        case (funct)
          FUNCT_ADD: alu_ctl = ALU_ADD;
          FUNCT_SUB: alu_ctl = ALU_SUB;
          FUNCT_AND: alu_ctl = ALU_AND;
          FUNCT_OR:  alu_ctl = ALU_OR;
          FUNCT_SLT: alu_ctl = ALU_SLT;
          default:   alu_ctl = ALU_NOP;
        endcase
      end
      default: alu_ctl = ALU_NOP;
    endcase
  end

  // ADD/SUB wrap modulo 2^DATA_W; no overflow detection.
  always_comb begin
    result = '0;
    case (alu_ctl)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_SLT: result = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/i_execute.sv
// Execute stage of the 5-stage MIPS pipeline.
// Takes the ID/EX bundle, computes ALU result, zero flag, branch target and
// destination register, and registers everything into the EX/MEM latch.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   wb_ctl[1:0], m_ctl[2:0]  control bundles, passed through unchanged
//   regdst                   1: dest = instr_1511, 0: dest = instr_2016
//   alusrc                   1: operand B = s_extend, 0: operand B = rdata2
//   aluop[1:0]               ALU op class
//   npc                      PC+4 of this instruction
//   rdata1, rdata2           register read values
//   s_extend                 sign-extended immediate ([5:0] = funct)
//   instr_2016, instr_1511   rt / rd fields
//   EX_MEM_*                 registered outputs to the memory stage
// The latch loads every cycle; there is no stall or hold. Reset loads a
// bubble (all zeros: no regwrite, no memwrite, no branch).
module i_execute
  import pipeline_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        wb_ctl,
  input  logic [2:0]        m_ctl,
  input  logic              regdst,
  input  logic              alusrc,
  input  logic [1:0]        aluop,
  input  logic [DATA_W-1:0] npc,
  input  logic [DATA_W-1:0] rdata1,
  input  logic [DATA_W-1:0] rdata2,
  input  logic [DATA_W-1:0] s_extend,
  input  logic [REG_AW-1:0] instr_2016,
  input  logic [REG_AW-1:0] instr_1511,
  output logic [1:0]        EX_MEM_wb_ctl,
  output logic [2:0]        EX_MEM_m_ctl,
  output logic [DATA_W-1:0] EX_MEM_npc,
  output logic              EX_MEM_zero,
  output logic [DATA_W-1:0] EX_MEM_alu_result,
  output logic [DATA_W-1:0] EX_MEM_rdata2,
  output logic [REG_AW-1:0] EX_MEM_rd
);

  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;
  logic [DATA_W-1:0] branch_target;
  logic [REG_AW-1:0] dest_reg;

  assign alu_b    = alusrc ? s_extend : rdata2;
  assign dest_reg = regdst ? instr_1511 : instr_2016;

  // Word offset shifted into a byte offset; the top two immediate bits fall
  // off and the sum wraps at DATA_W. Computed regardless of branch.
  assign branch_target = npc + {s_extend[DATA_W-3:0], 2'b00};

  alu #(
    .DATA_W(DATA_W)
  ) u_alu (
    .aluop (aluop),
    .funct (s_extend[5:0]),
    .a     (rdata1),
    .b     (alu_b),
    .result(alu_result),
    .zero  (alu_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      EX_MEM_wb_ctl     <= '0;
      EX_MEM_m_ctl      <= '0;
      EX_MEM_npc        <= '0;
      EX_MEM_zero       <= 1'b0;
      EX_MEM_alu_result <= '0;
      EX_MEM_rdata2     <= '0;
      EX_MEM_rd         <= '0;
    end else begin
      EX_MEM_wb_ctl     <= wb_ctl;
      EX_MEM_m_ctl      <= m_ctl;
      EX_MEM_npc        <= branch_target;
      EX_MEM_zero       <= alu_zero;
      EX_MEM_alu_result <= alu_result;
      EX_MEM_rdata2     <= rdata2;
      EX_MEM_rd         <= dest_reg;
    end
  end

endmodule

// File: tb/tb_i_execute.sv
// Directed testbench for the i_execute stage.
module tb_i_execute;

  logic        clk;
  logic        rst;
  logic [1:0]  wb_ctl;
  logic [2:0]  m_ctl;
  logic        regdst;
  logic        alusrc;
  logic [1:0]  aluop;
  logic [31:0] npc;
  logic [31:0] rdata1;
  logic [31:0] rdata2;
  logic [31:0] s_extend;
  logic [4:0]  instr_2016;
  logic [4:0]  instr_1511;
  logic [1:0]  ex_wb;
  logic [2:0]  ex_m;
  logic [31:0] ex_npc;
  logic        ex_zero;
  logic [31:0] ex_res;
  logic [31:0] ex_rdata2;
  logic [4:0]  ex_rd;

  int chk_cnt = 0;
  int err_cnt = 0;

  i_execute #(.DATA_W(32), .REG_AW(5)) dut (
    .clk              (clk),
    .rst              (rst),
    .wb_ctl           (wb_ctl),
    .m_ctl            (m_ctl),
    .regdst           (regdst),
    .alusrc           (alusrc),
    .aluop            (aluop),
    .npc              (npc),
    .rdata1           (rdata1),
    .rdata2           (rdata2),
    .s_extend         (s_extend),
    .instr_2016       (instr_2016),
    .instr_1511       (instr_1511),
    .EX_MEM_wb_ctl    (ex_wb),
    .EX_MEM_m_ctl     (ex_m),
    .EX_MEM_npc       (ex_npc),
    .EX_MEM_zero      (ex_zero),
    .EX_MEM_alu_result(ex_res),
    .EX_MEM_rdata2    (ex_rdata2),
    .EX_MEM_rd        (ex_rd)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached, required finish before 200000");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag,
                           input logic [1:0] e_wb, input logic [2:0] e_m,
                           input logic [31:0] e_npc, input logic e_zero,
                           input logic [31:0] e_res, input logic [31:0] e_rd2,
                           input logic [4:0] e_rd);
    check({tag, ".wb"},     {30'd0, ex_wb},   {30'd0, e_wb});
    check({tag, ".m"},      {29'd0, ex_m},    {29'd0, e_m});
    check({tag, ".npc"},    ex_npc,           e_npc);
    check({tag, ".zero"},   {31'd0, ex_zero}, {31'd0, e_zero});
    check({tag, ".res"},    ex_res,           e_res);
    check({tag, ".rdata2"}, ex_rdata2,        e_rd2);
    check({tag, ".rd"},     {27'd0, ex_rd},   {27'd0, e_rd});
  endtask

  // driver tasks
  task automatic apply(input logic [1:0] i_wb, input logic [2:0] i_m,
                       input logic i_regdst, input logic i_alusrc,
                       input logic [1:0] i_aluop, input logic [31:0] i_npc,
                       input logic [31:0] i_r1, input logic [31:0] i_r2,
                       input logic [31:0] i_se, input logic [4:0] i_rt,
                       input logic [4:0] i_rd);
    wb_ctl = i_wb; m_ctl = i_m; regdst = i_regdst; alusrc = i_alusrc;
    aluop = i_aluop; npc = i_npc; rdata1 = i_r1; rdata2 = i_r2;
    s_extend = i_se; instr_2016 = i_rt; instr_1511 = i_rd;
  endtask

  task automatic apply_random();
    apply(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          2'($urandom_range(0, 3)), $urandom, $urandom, $urandom, $urandom,
          5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
  endtask

  // one edge, then sample away from it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    apply_random();

    // reset: two edges with random inputs
    step();
    apply_random();
    check_all("rst1", 2'b00, 3'b000, 32'h0, 1'b0, 32'h0, 32'h0, 5'd0);
    step();
    check_all("rst2", 2'b00, 3'b000, 32'h0, 1'b0, 32'h0, 32'h0, 5'd0);
    rst = 1'b0;

    // R-type add 5+7, dest = rd field
    apply(2'b10, 3'b000, 1'b1, 1'b0, 2'b10, 32'h10, 32'd5, 32'd7, 32'h20, 5'd4, 5'd3);
    step();
    check_all("add", 2'b10, 3'b000, 32'h90, 1'b0, 32'd12, 32'd7, 5'd3);

    // SLT signed: -1 < 1
    apply(2'b10, 3'b000, 1'b1, 1'b0, 2'b10, 32'h0, 32'hFFFF_FFFF, 32'd1, 32'h2A, 5'd1, 5'd2);
    step();
    check("slt1.res", ex_res, 32'd1);
    check("slt1.zero", {31'd0, ex_zero}, 32'd0);
    // swapped: 1 < -1 is false
    apply(2'b10, 3'b000, 1'b1, 1'b0, 2'b10, 32'h0, 32'd1, 32'hFFFF_FFFF, 32'h2A, 5'd1, 5'd2);
    step();
    check("slt2.res", ex_res, 32'd0);
    check("slt2.zero", {31'd0, ex_zero}, 32'd1);

    // R-type sub wraps: 3-5
    apply(2'b10, 3'b000, 1'b1, 1'b0, 2'b10, 32'h0, 32'd3, 32'd5, 32'h22, 5'd1, 5'd6);
    step();
    check("sub.res", ex_res, 32'hFFFF_FFFE);
    // AND
    apply(2'b10, 3'b000, 1'b1, 1'b0, 2'b10, 32'h0, 32'hF0F0, 32'hFF00, 32'h24, 5'd1, 5'd6);
    step();
    check("and.res", ex_res, 32'h0000_F000);
    // OR
    apply(2'b10, 3'b000, 1'b1, 1'b0, 2'b10, 32'h0, 32'hF0F0, 32'h0F0F, 32'h25, 5'd1, 5'd6);
    step();
    check("or.res", ex_res, 32'h0000_FFFF);
    // unknown funct -> NOP
    apply(2'b10, 3'b000, 1'b1, 1'b0, 2'b10, 32'h0, 32'd1, 32'd2, 32'h3F, 5'd1, 5'd6);
    step();
    check("badfunct.res", ex_res, 32'h0);
    check("badfunct.zero", {31'd0, ex_zero}, 32'd1);
    // aluop=11 -> NOP even with a valid add funct
    apply(2'b10, 3'b000, 1'b1, 1'b0, 2'b11, 32'h0, 32'd1, 32'd2, 32'h20, 5'd1, 5'd6);
    step();
    check("aluop11.res", ex_res, 32'h0);

    // lw: 0x100 + (-4), immediate operand, dest = rt
    apply(2'b11, 3'b010, 1'b0, 1'b1, 2'b00, 32'h20, 32'h100, 32'h1234, 32'hFFFF_FFFC, 5'd8, 5'd9);
    step();
    check_all("lw", 2'b11, 3'b010, 32'h10, 1'b0, 32'hFC, 32'h1234, 5'd8);

    // beq taken, backwards branch
    apply(2'b00, 3'b100, 1'b0, 1'b0, 2'b01, 32'h40, 32'h55, 32'h55, 32'hFFFF_FFFF, 5'd2, 5'd0);
    step();
    check_all("beq", 2'b00, 3'b100, 32'h3C, 1'b1, 32'h0, 32'h55, 5'd2);
    // branch target wrap
    apply(2'b00, 3'b100, 1'b0, 1'b0, 2'b01, 32'hFFFF_FFFC, 32'h55, 32'h55, 32'h1, 5'd2, 5'd0);
    step();
    check("wrap.npc", ex_npc, 32'h0);

    // back-to-back with reset on the middle instruction
    apply(2'b10, 3'b000, 1'b0, 1'b0, 2'b00, 32'h8, 32'd10, 32'd20, 32'h4, 5'd5, 5'd6);
    step();
    check_all("b2b1", 2'b10, 3'b000, 32'h18, 1'b0, 32'd30, 32'd20, 5'd5);
    apply(2'b11, 3'b001, 1'b1, 1'b0, 2'b00, 32'hC, 32'd1, 32'd1, 32'h4, 5'd9, 5'd10);
    rst = 1'b1;
    step();
    check_all("b2b2rst", 2'b00, 3'b000, 32'h0, 1'b0, 32'h0, 32'h0, 5'd0);
    rst = 1'b0;
    apply(2'b10, 3'b001, 1'b1, 1'b0, 2'b10, 32'h100, 32'hC, 32'hA, 32'h24, 5'd1, 5'd7);
    step();
    check_all("b2b3", 2'b10, 3'b001, 32'h190, 1'b0, 32'd8, 32'hA, 5'd7);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/i_execute.md
Name: i_execute

Overview:
- Execute stage of the 5-stage MIPS pipeline. Sits directly downstream of the decode stage and consumes its ID/EX outputs: control bundles, NPC, both register read values, the sign-extended immediate and the rt/rd fields.
- Computes the ALU result, zero flag, branch target and destination register.
- Registers all of these into the EX/MEM latch for the memory stage. The latch's NPC and PCSrc-related fields feed back to fetch.

Parameters:
- DATA_W, 32, datapath width for operands, NPC and results.
- REG_AW, 5, register-specifier width.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- wb_ctl  in  2  WB control from ID/EX: {regwrite, memtoreg}; passed through unchanged.
- m_ctl  in  3  M control from ID/EX: {branch, memread, memwrite}; passed through unchanged.
- regdst  in  1  1 selects instr_1511 as destination, 0 selects instr_2016.
- alusrc  in  1  1 selects s_extend as ALU operand B, 0 selects rdata2.
- aluop  in  2  ALU op class from decode.
- npc  in  DATA_W  PC+4 of this instruction.
- rdata1  in  DATA_W  rs value (ALU operand A).
- rdata2  in  DATA_W  rt value (operand B or store data).
- s_extend  in  DATA_W  sign-extended immediate; bits [5:0] are the funct field.
- instr_2016  in  REG_AW  rt field.
- instr_1511  in  REG_AW  rd field.
- EX_MEM_wb_ctl  out  2  registered wb_ctl.
- EX_MEM_m_ctl  out  3  registered m_ctl.
- EX_MEM_npc  out  DATA_W  registered branch target.
- EX_MEM_zero  out  1  registered ALU zero flag.
- EX_MEM_alu_result  out  DATA_W  registered ALU result.
- EX_MEM_rdata2  out  DATA_W  registered rdata2 (store data).
- EX_MEM_rd  out  REG_AW  registered destination register.

Behaviour:
- Reset: clk and rst are the stage's only clock and reset; rst is synchronous, active-high. While rst=1 at a rising edge, all EX/MEM outputs load 0. This is a bubble: no regwrite, no memwrite, no branch. A reset asserted mid-stream discards the in-flight instruction. The first valid capture happens at the first edge with rst=0.
- Latency: exactly 1 cycle. Inputs sampled at edge N appear on outputs after edge N. No stall or hold; the latch loads every cycle.
- ALU control (combinational), by aluop:
  - 00 -> ADD (load/store address).
  - 01 -> SUB (beq compare).
  - 10 -> decoded from funct = s_extend[5:0]: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT.
  - 11, or any other funct -> NOP; result forced to 0.
- ALU control codes: AND=000, OR=001, ADD=010, SUB=110, SLT=111, NOP=011.
- ALU arithmetic:
  - Operand B = alusrc ? s_extend : rdata2.
  - ADD and SUB wrap modulo 2^DATA_W; no overflow trap or flag.
  - SLT is signed two's-complement: result = {DATA_W-1 zeros, (A<B signed)}.
  - zero = (result == 0); NOP therefore gives zero=1.
- Branch target = npc + (s_extend << 2), truncated to DATA_W (wraps, e.g. 0xFFFFFFFC+4 -> 0). Always computed, whether or not branch is set.
- Destination: rd = regdst ? instr_1511 : instr_2016.
- Control bundles and rdata2 pass through untouched. The stage never modifies or gates control bits.
- X-free: all outputs are defined after reset regardless of input X before the first capture.

Decomposition:
- Package (pipeline_pkg):
  - aluop codes (ALUOP_ADD=2'b00, ALUOP_SUB=2'b01, ALUOP_RTYPE=2'b10).
  - ALU control codes listed above.
  - funct constants.
  - Bit positions within wb_ctl and m_ctl (WB_REGWRITE=1, WB_MEMTOREG=0, M_BRANCH=2, M_MEMREAD=1, M_MEMWRITE=0).
- Sub-module: alu. Holds ALU-control decode plus the ALU datapath, produces result and zero; purely combinational.
- i_execute instantiates alu, the two muxes, the branch adder and the EX/MEM register.

Test Plan:
1. Reset: rst=1 for 2 cycles with random inputs -> all outputs 0. Release rst -> the next edge captures inputs.
2. R-type add: aluop=10, funct=100000, alusrc=0, rdata1=5, rdata2=7, regdst=1, instr_1511=3, wb_ctl=10 -> after 1 edge: alu_result=12, zero=0, rd=3, wb_ctl=10.
3. SLT signed: aluop=10, funct=101010, rdata1=0xFFFFFFFF, rdata2=1 -> result=1. Then swap the operands -> result=0, zero=1.
4. lw: aluop=00, alusrc=1, rdata1=0x100, s_extend=0xFFFFFFFC, regdst=0, instr_2016=8, m_ctl=010 -> result=0xFC, rd=8, m_ctl=010.
5. beq taken: aluop=01, rdata1=rdata2=0x55, npc=0x40, s_extend=0xFFFFFFFF, m_ctl=100 -> zero=1, npc_out=0x3C, m_ctl=100. Branch-target wrap: npc=0xFFFFFFFC, s_extend=1 -> npc_out=0x0.
6. Back-to-back plus mid-stream reset: three instructions on consecutive cycles produce three consecutive results, one per edge. Assert rst on cycle 2 -> that cycle's output is all zeros, and instruction 3 still appears correctly after reset is released.
